// File: rtl/seq_det_ctrl.sv
// Programmable serial sequence detector controller with start/abort handshake.
// Define SEQ_DET_OVERLAP_EN to let overlapping occurrences count.
module seq_det_ctrl #(
    parameter int PW = 8,
    parameter int CW = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [PW-1:0]           cfg_pattern,
    input  logic [$clog2(PW+1)-1:0] cfg_len,
    input  logic [CW-1:0]           cfg_thresh,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    x_valid,
    input  logic                    x,
    output logic                    busy,
    output logic                    match,
    output logic [CW-1:0]           match_cnt,
    output logic                    done,
    output logic                    err
);

    localparam int LW = $clog2(PW + 1);

`ifdef SEQ_DET_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    state_t        state;
    logic [PW-1:0] pat;
    logic [PW-1:0] hist;
    logic [LW-1:0] len;
    logic [LW-1:0] fill;
    logic [CW-1:0] thr;

    logic [PW-1:0] hnext;
    logic [PW-1:0] mask;
    logic [LW-1:0] fnext;
    logic [LW-1:0] elen;
    logic [CW-1:0] cinc;
    logic          hit;
    logic          full;
    logic          legal;
    logic          arm;

    assign hnext = {hist[PW-2:0], x};
    assign fnext = fill + LW'(1);
    assign full  = (state == RUN) || (fnext == len);
    assign hit   = ((hnext ^ pat) & mask) == '0;
    // A same-cycle config write is the one the legality check must see.
    assign elen  = cfg_we ? cfg_len : len;
    assign legal = (elen != '0) && (elen <= LW'(PW));
    assign cinc  = (match_cnt == '1) ? match_cnt : match_cnt + CW'(1);
    assign arm   = start && !abort;

    always_comb begin
        mask = '0;
        for (int i = 0; i < PW; i++) begin
            if (LW'(i) < len) mask[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pat       <= '0;
            len       <= '0;
            thr       <= '0;
            hist      <= '0;
            fill      <= '0;
            busy      <= 1'b0;
            match     <= 1'b0;
            match_cnt <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            match <= 1'b0;
            err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cfg_we) begin
                        pat <= cfg_pattern;
                        len <= cfg_len;
                        thr <= cfg_thresh;
                    end
                    if (arm && legal) begin
                        state     <= FILL;
                        busy      <= 1'b1;
                        hist      <= '0;
                        fill      <= '0;
                        match_cnt <= '0;
                    end else if (arm) begin
                        err <= 1'b1;
                    end
                end
                FILL, RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (x_valid) begin
                        hist <= hnext;
                        if (state == FILL) fill <= fnext;
                        if (full) begin
                            state <= RUN;
                            if (hit) begin
                                match     <= 1'b1;
                                match_cnt <= cinc;
                                if (thr != '0 && cinc == thr) begin
                                    state <= DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end else if (!OVL) begin
                                    hist  <= '0;
                                    fill  <= '0;
                                    state <= FILL;
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    if (arm) begin
                        state     <= FILL;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        hist      <= '0;
                        fill      <= '0;
                        match_cnt <= '0;
                    end
                end
            endcase
        end
    end

endmodule
